sha256_req_arbiter: RTL

Shares one SHA-256 single-block hashing core among N requesters, for example the key-derivation and image-block integrity units in the chaos encryption pipeline. Requesters submit pre-padded 512-bit blocks. The block selects one requester round-robin, holds that requester's block stable for the core, and pulses the core start. It then waits for the core's done pulse and returns the 256-bit digest to the granted requester. A watchdog flags a core that never completes.

---
 rtl/sha256_req_arbiter_pkg.sv | 14 +
 rtl/sha256_req_arbiter_if.sv | 32 +++
 rtl/sha256_req_arbiter_rr_arbiter.sv | 36 +++
 rtl/sha256_req_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/sha256_req_arbiter_pkg.sv
// Shared types and widths for the SHA-256 request arbiter.
package sha256_arb_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/sha256_req_arbiter_if.sv
// Requester and core-side bundle of the SHA-256 request arbiter.
interface sha256_req_arbiter_if
    import sha256_arb_pkg::*;
#(
    parameter int N = 4
);

    logic [N-1:0]         req_valid;
    logic [N*BLOCK_W-1:0] req_block;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [DIGEST_W-1:0]  rsp_digest;
    logic                 rsp_err;
    logic                 busy;
    logic                 core_go;
    logic [BLOCK_W-1:0]   core_block;
    logic [DIGEST_W-1:0]  core_digest;
    logic                 core_done;

    // Arbiter side
    modport slave (
        input  req_valid, req_block, core_digest, core_done,
        output req_ready, rsp_valid, rsp_digest, rsp_err, busy, core_go, core_block
    );

    // Requesters plus core side
    modport master (
        output req_valid, req_block, core_digest, core_done,
        input  req_ready, rsp_valid, rsp_digest, rsp_err, busy, core_go, core_block
    );

endinterface

// File: rtl/sha256_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan last_grant+1 .. last_grant+N (mod N) and keep the first hit
    always_comb begin
        logic             found;
        int               pos;
        logic [IDX_W-1:0] p;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        p       = '0;
        for (int k = 1; k <= N; k++) begin
            pos = int'(last_grant_i) + k;
            if (pos >= N) pos = pos - N;
            p = IDX_W'(pos);
            if (!found && req_i[p]) begin
                found      = 1'b1;
                grant_o[p] = 1'b1;
                idx_o      = p;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sha256_req_arbiter.sv
// Shares one SHA-256 single-block core among N requesters, one job at a time,
// with round-robin grant and a watchdog that aborts a core that never finishes.
module sha256_req_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_req_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     wd_q, wd_d;
    logic [BLOCK_W-1:0]   blk_q, blk_d;
    logic [DIGEST_W-1:0]  dig_q, dig_d;
    logic                 err_q, err_d;

    logic [N-1:0]         grant;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;

    rr_arbiter #(.N(N)) u_rr (
        .req_i        (bus.req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .idx_o        (win_idx),
        .any_o        (win_any)
    );

    assign bus.busy       = (state_q != IDLE);
    assign bus.core_block = blk_q;
    assign bus.rsp_digest = dig_q;

    // State and datapath registers; last_q starts at N-1 so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(N - 1);
            wd_q    <= '0;
            blk_q   <= '0;
            dig_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            blk_q   <= blk_d;
            dig_q   <= dig_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode; done beats timeout when both land together
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        last_d        = last_q;
        wd_d          = wd_q;
        blk_d         = blk_q;
        dig_d         = dig_q;
        err_d         = err_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_err   = 1'b0;
        bus.core_go   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = grant;
                if (win_any) begin
                    for (int i = 0; i < N; i++) begin
                        if (grant[i]) blk_d = bus.req_block[i*BLOCK_W +: BLOCK_W];
                    end
                    idx_d   = win_idx;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                bus.core_go = 1'b1;
                wd_d        = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (bus.core_done) begin
                    dig_d   = bus.core_digest;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == CNT_W'(TIMEOUT)) begin
                    dig_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                bus.rsp_valid[idx_q] = 1'b1;
                bus.rsp_err          = err_q;
                last_d               = idx_q;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
